// File: rtl/ifu_fetch_buf.sv
// Fetch unit with a small {pc, inst} FIFO between the ROM and decode.
// Define IFU_BYPASS_EN to let an empty buffer hand the ROM word straight to decode.
module ifu_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        dec_valid_o,
    output logic [31:0] dec_inst_o,
    output logic [31:0] dec_pc_o,
    input  logic        dec_ready_i
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]             pc_q, pc_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic [DEPTH-1:0][31:0]  mem_pc_q, mem_pc_d;
    logic [DEPTH-1:0][31:0]  mem_inst_q, mem_inst_d;

    logic fifo_valid;
    logic full;
    logic pop;
    logic push;
    logic bypass;

    assign fifo_valid  = (cnt_q != '0);
    // DEPTH is a power of two and cnt never exceeds it, so the top bit means full
    assign full        = cnt_q[AW];
    assign pop         = fifo_valid && dec_ready_i;
    assign inst_addr_o = pc_q;

`ifdef IFU_BYPASS_EN
    assign bypass = !fifo_valid && !jump_en_i && dec_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = !jump_en_i && !bypass && (!full || pop);

    always_comb begin
        dec_valid_o = fifo_valid;
        dec_inst_o  = '0;
        dec_pc_o    = '0;
        if (fifo_valid) begin
            dec_inst_o = mem_inst_q[rptr_q];
            dec_pc_o   = mem_pc_q[rptr_q];
        end else if (bypass) begin
            dec_valid_o = 1'b1;
            dec_inst_o  = inst_i;
            dec_pc_o    = pc_q;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        if (jump_en_i) begin
            // a redirect discards everything, including an entry popped this cycle
            pc_d   = {jump_addr_i[31:2], 2'b00};
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push) begin
                mem_pc_d[wptr_q]   = pc_q;
                mem_inst_d[wptr_q] = inst_i;
                wptr_d             = wptr_q + AW'(1);
            end
            if (push || bypass) begin
                pc_d = pc_q + 32'd4;
            end
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            mem_pc_q   <= '0;
            mem_inst_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            mem_pc_q   <= mem_pc_d;
            mem_inst_q <= mem_inst_d;
        end
    end

endmodule
